// File: rtl/useq_pkg.sv
// useq_pkg: opcodes, microword field positions and FSM states for the microprogram sequencer.
package useq_pkg;
   localparam logic [2:0] OP_SEL  = 3'd0;
   localparam logic [2:0] OP_WRI  = 3'd1;
   localparam logic [2:0] OP_WRD  = 3'd2;
   localparam logic [2:0] OP_JMP  = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CALL = 3'd5;
   localparam logic [2:0] OP_RET  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 13;
   localparam int REG_HI = 12;
   localparam int REG_LO = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
endpackage

// File: rtl/useq_stack.sv
// useq_stack: return-address LIFO; push/pop are ignored when full/empty respectively.
module useq_stack #(
   parameter int DEPTH = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int SP_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [SP_W-1:0] sp;
   assign full = sp == SP_W'(DEPTH);
   assign empty = sp == '0;
   assign dout = empty ? '0 : mem[IDX_W'(sp - SP_W'(1))];
   always_ff @(posedge clk)
      if (push && !full) mem[IDX_W'(sp)] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) sp <= '0;
      else if (push && !full) sp <= sp + SP_W'(1);
      else if (pop && !empty) sp <= sp - SP_W'(1);
endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: two-cycle-per-microword sequencer driving the register file f_we/fsel/fin interface.
module useq_ctrl
   import useq_pkg::*;
#(
   parameter int UADDR_W = 8,
   parameter int UWORD_W = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [UADDR_W-1:0] start_addr,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [UADDR_W-1:0] rom_addr,
   input  logic [UWORD_W-1:0] rom_data,
   input  logic               cond_in,
   output logic               f_we,
   output logic [4:0]         fsel,
   output logic               fin_sel,
   output logic [7:0]         imm
);
   state_t state, state_n;
   logic [UADDR_W-1:0] upc, upc_n, upc_inc, stk_dout;
   logic [4:0] cur_addr, cur_n;
   logic busy_n, done_n, err_n, f_we_n, fin_sel_n;
   logic [7:0] imm_n;
   logic [2:0] op;
   logic [4:0] reg_f;
   logic [7:0] tgt;
   logic exec, push, pop, full, empty, stk_err;
   assign op = rom_data[OP_HI:OP_LO];
   assign reg_f = rom_data[REG_HI:REG_LO];
   assign tgt = rom_data[IMM_HI:IMM_LO];
   assign exec = state == EXEC;
   assign upc_inc = upc + UADDR_W'(1);
   assign push = exec && op == OP_CALL && !full;
   assign pop = exec && op == OP_RET && !empty;
   assign stk_err = exec && ((op == OP_CALL && full) || (op == OP_RET && empty));
   // ROM is synchronous: presenting upc through FETCH yields the word in EXEC
   assign rom_addr = upc;
   assign fsel = cur_addr;
   useq_stack #(.DEPTH(STACK_DEPTH), .W(UADDR_W)) u_stack (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(upc_inc),
      .dout(stk_dout), .full(full), .empty(empty)
   );
   always_comb begin
      state_n = state;
      upc_n = upc;
      cur_n = cur_addr;
      busy_n = busy;
      done_n = 1'b0;
      err_n = err;
      f_we_n = 1'b1;
      fin_sel_n = 1'b0;
      imm_n = '0;
      case (state)
         IDLE: if (start) begin
            state_n = FETCH;
            upc_n = start_addr;
            err_n = 1'b0;
            busy_n = 1'b1;
         end
         FETCH: state_n = EXEC;
         EXEC: begin
            state_n = FETCH;
            upc_n = upc_inc;
            case (op)
               OP_SEL: cur_n = reg_f;
               OP_WRI, OP_WRD: begin
                  f_we_n = 1'b0;
                  fin_sel_n = op == OP_WRI;
                  imm_n = tgt;
               end
               OP_JMP, OP_CALL: upc_n = UADDR_W'(tgt);
               OP_BZ: upc_n = cond_in ? upc_inc : UADDR_W'(tgt);
               OP_RET: upc_n = stk_dout;
               default: begin
                  state_n = IDLE;
                  busy_n = 1'b0;
                  done_n = 1'b1;
               end
            endcase
            if (stk_err) begin
               state_n = IDLE;
               busy_n = 1'b0;
               err_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         upc <= '0;
         cur_addr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         f_we <= 1'b1;
         fin_sel <= 1'b0;
         imm <= '0;
      end else begin
         state <= state_n;
         upc <= upc_n;
         cur_addr <= cur_n;
         busy <= busy_n;
         done <= done_n;
         err <= err_n;
         f_we <= f_we_n;
         fin_sel <= fin_sel_n;
         imm <= imm_n;
      end
endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: directed programs with a scoreboard of expected fetches and register-file writes.
module tb_useq_ctrl;
   localparam logic [2:0] SEL = 3'd0, WRI = 3'd1, WRD = 3'd2, JMP = 3'd3;
   localparam logic [2:0] BZ = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;
   logic clk, reset, start, cond_in;
   logic [7:0] start_addr, rom_addr, imm;
   logic busy, done, err, f_we, fin_sel;
   logic [4:0] fsel;
   logic [15:0] rom_data;
   logic [15:0] rom [256];
   int checks = 0, failures = 0, done_cnt = 0, bc, e_f, e_w;
   bit phase;
   int exp_fetch[$];
   int exp_wr[$];

   useq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .busy(busy), .done(done), .err(err), .rom_addr(rom_addr),
      .rom_data(rom_data), .cond_in(cond_in), .f_we(f_we), .fsel(fsel),
      .fin_sel(fin_sel), .imm(imm)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   function automatic logic [15:0] mw(input logic [2:0] op, input logic [4:0] r, input logic [7:0] t);
      return {op, r, t};
   endfunction

   function automatic int wr(input int f, input int s, input int i);
      return (f << 9) | (s << 8) | i;
   endfunction

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: a fetch is the first cycle of each two-cycle busy pair
   always @(negedge clk) begin
      if (reset || !busy) phase = 0;
      else if (!phase) begin
         e_f = exp_fetch.size() > 0 ? exp_fetch.pop_front() : -1;
         chk("fetch", int'(rom_addr), e_f);
         phase = 1;
      end else phase = 0;
      if (!reset && !f_we) begin
         e_w = exp_wr.size() > 0 ? exp_wr.pop_front() : -1;
         chk("write", int'({fsel, fin_sel, imm}), e_w);
      end
      if (!reset && done) done_cnt++;
   end

   task automatic run(input logic [7:0] a, input int poke, output int n);
      start = 1;
      start_addr = a;
      tick();
      start = 0;
      n = 0;
      while (busy && n < 100) begin
         start = (n == poke);
         start_addr = 8'h90;
         n++;
         tick();
      end
      start = 0;
      chk("run_bounded", int'(n < 100), 1);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[8'h10] = mw(SEL, 5'd5, 8'h00);
      rom[8'h11] = mw(WRI, 5'd0, 8'hA5);
      rom[8'h12] = mw(HALT, 5'd0, 8'h00);
      rom[8'h30] = mw(BZ, 5'd0, 8'h40);
      rom[8'h31] = mw(HALT, 5'd0, 8'h00);
      rom[8'h40] = mw(HALT, 5'd0, 8'h00);
      rom[8'h20] = mw(CALL, 5'd0, 8'h80);
      rom[8'h21] = mw(HALT, 5'd0, 8'h00);
      rom[8'h80] = mw(RET, 5'd0, 8'h00);
      for (int i = 0; i < 5; i++) rom[8'h50 + i] = mw(CALL, 5'd0, 8'(8'h51 + i));
      rom[8'h60] = mw(JMP, 5'd0, 8'hFF);
      rom[8'hFF] = mw(WRD, 5'd3, 8'h3C);
      rom[8'h00] = mw(HALT, 5'd0, 8'h00);
      reset = 1; start = 0; start_addr = 0; cond_in = 0;
      tick(); tick();
      chk("rst_f_we", int'(f_we), 1);
      chk("rst_busy", int'(busy), 0);
      reset = 0;
      tick();
      // basic program
      exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
      exp_wr.push_back(wr(5, 1, 8'hA5));
      run(8'h10, -1, bc);
      chk("basic_busy_cycles", bc, 6);
      chk("basic_done", done_cnt, 1);
      chk("basic_err", int'(err), 0);
      chk("idle_fsel", int'(fsel), 5);
      // reset during EXEC of WRI
      exp_fetch.push_back(8'h11);
      start = 1; start_addr = 8'h11; tick(); start = 0; tick();
      chk("pre_rst_rom_addr", int'(rom_addr), 8'h11);
      reset = 1;
      #1;
      chk("mid_rst_f_we", int'(f_we), 1);
      chk("mid_rst_fsel", int'(fsel), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_err", int'(err), 0);
      chk("mid_rst_rom_addr", int'(rom_addr), 0);
      tick(); reset = 0; tick(); tick();
      chk("post_rst_done", done_cnt, 1);
      // branch taken / not taken
      cond_in = 0;
      exp_fetch.push_back(8'h30); exp_fetch.push_back(8'h40);
      run(8'h30, -1, bc);
      cond_in = 1;
      exp_fetch.push_back(8'h30); exp_fetch.push_back(8'h31);
      run(8'h30, -1, bc);
      cond_in = 0;
      chk("bz_done", done_cnt, 3);
      // call / return
      exp_fetch.push_back(8'h20); exp_fetch.push_back(8'h80); exp_fetch.push_back(8'h21);
      run(8'h20, -1, bc);
      chk("call_done", done_cnt, 4);
      chk("call_err", int'(err), 0);
      // stack overflow on fifth nested call
      for (int i = 0; i < 5; i++) exp_fetch.push_back(8'h50 + i);
      run(8'h50, -1, bc);
      chk("ovf_err", int'(err), 1);
      chk("ovf_busy", int'(busy), 0);
      chk("ovf_no_done", done_cnt, 4);
      chk("ovf_busy_cycles", bc, 10);
      tick();
      chk("ovf_err_sticky", int'(err), 1);
      exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
      exp_wr.push_back(wr(5, 1, 8'hA5));
      run(8'h10, -1, bc);
      chk("err_cleared", int'(err), 0);
      chk("rerun_done", done_cnt, 5);
      // wrap 0xFF -> 0x00 with an ignored start while busy
      exp_fetch.push_back(8'h60); exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00);
      exp_wr.push_back(wr(5, 0, 8'h3C));
      run(8'h60, 2, bc);
      chk("wrap_busy_cycles", bc, 6);
      chk("wrap_done", done_cnt, 6);
      chk("fetch_q_drained", exp_fetch.size(), 0);
      chk("write_q_drained", exp_wr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
